// File: rtl/gcd_operand_sequencer.sv
// Pairs consecutive input words into (A,B) operands for the GCD coprocessor and
// throttles issue on in-flight results. Optional GCD_SORT_EN orders the pair so A >= B.
module gcd_operand_sequencer #(
  parameter int W               = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [W-1:0]     in_bits,
  output logic             operands_val,
  input  logic             operands_rdy,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  input  logic             mon_result_val,
  input  logic             mon_result_rdy,
  output logic [7:0]       outstanding,
  output logic [CNT_W-1:0] issued_count,
  output logic             underflow_err
);

  typedef enum logic [1:0] {GET_A, GET_B, ISSUE} state_t;

  localparam logic [7:0] MAX_O = 8'(MAX_OUTSTANDING);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [7:0]       out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_fire, iss, ret;

  // Handshake qualifiers come only from registered state.
  assign in_rdy       = (state_q == GET_A) || (state_q == GET_B);
  assign operands_val = (state_q == ISSUE) && (out_q < MAX_O);
  assign in_fire      = in_val && in_rdy;
  assign iss          = operands_val && operands_rdy;
  assign ret          = mon_result_val && mon_result_rdy;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      GET_A: if (in_fire) begin
        a_d     = in_bits;
        state_d = GET_B;
      end
      GET_B: if (in_fire) begin
`ifdef GCD_SORT_EN
        if (in_bits > a_q) begin
          a_d = in_bits;
          b_d = a_q;
        end else begin
          b_d = in_bits;
        end
`else
        b_d = in_bits;
`endif
        state_d = ISSUE;
      end
      ISSUE: if (iss) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  // A simultaneous issue and return cancel, including at zero outstanding.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (iss) cnt_d = cnt_q + CNT_W'(1);
    case ({iss, ret})
      2'b10: out_d = out_q + 8'd1;
      2'b01: begin
        if (out_q == 8'd0) err_d = 1'b1;
        else               out_d = out_q - 8'd1;
      end
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign operands_bits_A = a_q;
  assign operands_bits_B = b_q;
  assign outstanding     = out_q;
  assign issued_count    = cnt_q;
  assign underflow_err   = err_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer: table-driven pairs plus throttle, snoop,
// reset and wrap sequences. Expected pair ordering follows GCD_SORT_EN.
module tb_gcd_operand_sequencer;
  localparam int W = 32, MAXO = 4, CW = 4;

  logic          clk = 1'b0, reset = 1'b0;
  logic          in_val = 1'b0, in_rdy;
  logic [W-1:0]  in_bits = '0;
  logic          operands_val, operands_rdy = 1'b1;
  logic [W-1:0]  op_a, op_b;
  logic          mon_val = 1'b0, mon_rdy = 1'b0;
  logic [7:0]    outstanding;
  logic [CW-1:0] issued_count;
  logic          underflow_err;

  int checks = 0, failures = 0, exp_cnt = 0;

  gcd_operand_sequencer #(.W(W), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_bits(in_bits),
    .operands_val(operands_val), .operands_rdy(operands_rdy),
    .operands_bits_A(op_a), .operands_bits_B(op_b),
    .mon_result_val(mon_val), .mon_result_rdy(mon_rdy),
    .outstanding(outstanding), .issued_count(issued_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, ea, eb;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    in_val  = 1'b1;
    in_bits = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk); #1;
        in_val = 1'b0;
        return;
      end
    end
    chk("send_word_timeout", 0, 1);
    in_val = 1'b0;
  endtask

  // Pair must be presented in the cycle after B is accepted.
  task automatic issue_pair(input string nm, input logic [W-1:0] a, b, ea, eb, input bit ret_same);
    send_word(a);
    send_word(b);
    @(negedge clk);
    chk({nm, "_val"}, operands_val, 1);
    chk({nm, "_A"}, op_a, ea);
    chk({nm, "_B"}, op_b, eb);
    if (ret_same) begin mon_val = 1'b1; mon_rdy = 1'b1; end
    @(posedge clk); #1;
    mon_val = 1'b0; mon_rdy = 1'b0;
    exp_cnt++;
  endtask

  task automatic ret_pulse();
    mon_val = 1'b1; mon_rdy = 1'b1;
    @(posedge clk); #1;
    mon_val = 1'b0; mon_rdy = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_val", operands_val, 0);
    chk("rst_A", op_a, 0);
    chk("rst_B", op_b, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_cnt", issued_count, 0);
    chk("rst_err", underflow_err, 0);
    exp_cnt = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_rdy", in_rdy, 1);
  endtask

  initial begin
    vt[0] = '{a: 6,   b: 35,  ea: 6,   eb: 35};
    vt[1] = '{a: 9,   b: 9,   ea: 9,   eb: 9};
    vt[2] = '{a: 0,   b: 0,   ea: 0,   eb: 0};
    vt[3] = '{a: 0,   b: 5,   ea: 0,   eb: 5};
    vt[4] = '{a: 100, b: 1,   ea: 100, eb: 1};
    vt[5] = '{a: 32'hFFFF_FFFF, b: 32'h7FFF_FFFF, ea: 32'hFFFF_FFFF, eb: 32'h7FFF_FFFF};
`ifdef GCD_SORT_EN
    vt[0].ea = 35; vt[0].eb = 6;
    vt[3].ea = 5;  vt[3].eb = 0;
`endif

    repeat (3) @(posedge clk);
    do_reset();

    // Basic pair and latency
    issue_pair("t1", 27, 15, 27, 15, 0);
    chk("t1_cnt", issued_count, 1);
    chk("t1_out", outstanding, 1);
    chk("t1_in_rdy", in_rdy, 1);
    ret_pulse();
    chk("t1_out_ret", outstanding, 0);

    for (int i = 0; i < 6; i++) begin
      issue_pair($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].ea, vt[i].eb, 0);
      chk($sformatf("vec%0d_cnt", i), issued_count, 64'(CW'(exp_cnt)));
      chk($sformatf("vec%0d_out", i), outstanding, 1);
      ret_pulse();
    end
    chk("vec_out_end", outstanding, 0);

    // Issue with simultaneous return at zero: no error
    issue_pair("sim0", 1, 1, 1, 1, 1);
    chk("sim0_out", outstanding, 0);
    chk("sim0_err", underflow_err, 0);

    // Issue and return on the same edge at outstanding=2
    issue_pair("o1", 2, 2, 2, 2, 0);
    issue_pair("o2", 3, 3, 3, 3, 0);
    chk("o2_out", outstanding, 2);
    issue_pair("o3", 4, 4, 4, 4, 1);
    chk("same_edge_out", outstanding, 2);
    ret_pulse(); ret_pulse();
    chk("drain_out", outstanding, 0);
    chk("drain_err", underflow_err, 0);
    ret_pulse();
    chk("uf_err", underflow_err, 1);
    chk("uf_out", outstanding, 0);

    // Throttle at MAX_OUTSTANDING
    for (int i = 0; i < 4; i++) issue_pair($sformatf("thr%0d", i), 40, 41, 40, 41, 0);
    chk("thr_out4", outstanding, 4);
    send_word(10);
    send_word(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("thr_val0", operands_val, 0);
      chk("thr_in_rdy0", in_rdy, 0);
`ifdef GCD_SORT_EN
      chk("thr_A_hold", op_a, 20);
`else
      chk("thr_A_hold", op_a, 10);
`endif
    end
    @(posedge clk); #1;
    in_val = 1'b1; in_bits = 77;   // must stall, not drop
    ret_pulse();
    @(negedge clk);
    chk("thr_val_rise", operands_val, 1);
    chk("thr_out3", outstanding, 3);
    chk("thr_stall_rdy", in_rdy, 0);
    @(posedge clk); #1;
    exp_cnt++;
    chk("thr_out_back4", outstanding, 4);
    @(negedge clk);
    chk("stall_in_rdy", in_rdy, 1);
    @(posedge clk); #1;
    in_val = 1'b0;
    operands_rdy = 1'b0;
    send_word(2);
    @(negedge clk);
    chk("stall_A", op_a, 77);
    chk("stall_B", op_b, 2);
    chk("stall_val", operands_val, 0);
    @(posedge clk); #1;
    repeat (4) ret_pulse();
    chk("hold_out0", outstanding, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_val", operands_val, 1);
      chk("hold_A", op_a, 77);
      chk("hold_B", op_b, 2);
    end
    chk("err_sticky", underflow_err, 1);
    operands_rdy = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    chk("hold_issue_out", outstanding, 1);
    chk("hold_issue_cnt", issued_count, 64'(CW'(exp_cnt)));
    mon_val = 1'b1; mon_rdy = 1'b0;
    @(posedge clk); #1;
    mon_val = 1'b0;
    chk("val_only_no_ret", outstanding, 1);
    ret_pulse();

    // Reset mid-pair
    operands_rdy = 1'b0;
    send_word(8);
    send_word(4);
    @(negedge clk);
    chk("r_pre_A", op_a, 8);
    do_reset();
    operands_rdy = 1'b1;
    send_word(50);
    do_reset();
`ifdef GCD_SORT_EN
    issue_pair("fresh", 3, 7, 7, 3, 0);
`else
    issue_pair("fresh", 3, 7, 3, 7, 0);
`endif
    chk("fresh_cnt", issued_count, 1);
    ret_pulse();

    // Wrap of the issued counter
    for (int i = 0; i < 16; i++) begin
      issue_pair("wrap", 5, 5, 5, 5, 0);
      ret_pulse();
      if (i == 14) chk("wrap_zero", issued_count, 0);
    end
    chk("wrap_one", issued_count, 1);
    chk("wrap_out", outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
